regfile_scoreboard: RTL and testbench



---
 rtl/regfile_scoreboard_if.sv | 34 +++
 rtl/regfile_scoreboard.sv | 80 ++++++++
 tb/tb_regfile_scoreboard.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Decode-issue / write-back bus into the register-file scoreboard.
interface regfile_scoreboard_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 2
);
  localparam int unsigned NREG  = 1 << ADDR_W;
  localparam int unsigned TOT_W = ADDR_W + CNT_W;

  logic              flush;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_src1;
  logic [ADDR_W-1:0] issue_src2;
  logic              issue_use_src2;
  logic              issue_wr;
  logic [ADDR_W-1:0] issue_dest;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_dest;
  logic              stall;
  logic              issue_fire;
  logic [NREG-1:0]   busy_mask;
  logic [TOT_W-1:0]  total_pending;

  modport master (
    output flush, issue_valid, issue_src1, issue_src2, issue_use_src2,
           issue_wr, issue_dest, wb_en, wb_dest,
    input  stall, issue_fire, busy_mask, total_pending
  );

  modport slave (
    input  flush, issue_valid, issue_src1, issue_src2, issue_use_src2,
           issue_wr, issue_dest, wb_en, wb_dest,
    output stall, issue_fire, busy_mask, total_pending
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register in-flight write counters and decode stall generation.
module regfile_scoreboard #(
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  sb
);
  localparam int unsigned NREG    = 1 << ADDR_W;
  localparam int unsigned TOT_W   = ADDR_W + CNT_W;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NREG-1:0]            busy_q, busy_d;
  logic [TOT_W-1:0]           total_q, total_d;

  logic [CNT_W-1:0] cnt_s1, cnt_s2, cnt_dst, cnt_wb;
  logic             pend_s1, pend_s2, sat_dst;
  logic             stall_c, fire_c, inc_c, dec_c, same_c;

  // Source hazards with same-cycle write-back bypass, and destination saturation.
  always_comb begin
    cnt_s1  = cnt_q[sb.issue_src1];
    cnt_s2  = cnt_q[sb.issue_src2];
    cnt_dst = cnt_q[sb.issue_dest];
    pend_s1 = (sb.issue_src1 != '0) && (cnt_s1 != '0) &&
              !(sb.wb_en && (sb.wb_dest == sb.issue_src1) && (cnt_s1 == CNT_W'(1)));
    pend_s2 = (sb.issue_src2 != '0) && (cnt_s2 != '0) &&
              !(sb.wb_en && (sb.wb_dest == sb.issue_src2) && (cnt_s2 == CNT_W'(1)));
    sat_dst = sb.issue_wr && (sb.issue_dest != '0) && (cnt_dst == CNT_W'(CNT_MAX)) &&
              !(sb.wb_en && (sb.wb_dest == sb.issue_dest));
    stall_c = sb.issue_valid && (pend_s1 || (sb.issue_use_src2 && pend_s2) || sat_dst);
    fire_c  = sb.issue_valid && !stall_c;
  end

  assign sb.stall         = stall_c;
  assign sb.issue_fire    = fire_c;
  assign sb.busy_mask     = busy_q;
  assign sb.total_pending = total_q;

  // Next counter state: flush clears, matching inc/dec on one register cancel.
  always_comb begin
    cnt_d   = cnt_q;
    total_d = total_q;
    busy_d  = '0;
    cnt_wb  = cnt_q[sb.wb_dest];
    inc_c   = fire_c && sb.issue_wr && (sb.issue_dest != '0);
    dec_c   = sb.wb_en && (sb.wb_dest != '0) && (cnt_wb != '0);
    same_c  = inc_c && dec_c && (sb.issue_dest == sb.wb_dest);
    if (sb.flush) begin
      cnt_d   = '0;
      total_d = '0;
    end else begin
      if (inc_c && !same_c) cnt_d[sb.issue_dest] = cnt_dst + CNT_W'(1);
      if (dec_c && !same_c) cnt_d[sb.wb_dest]    = cnt_wb - CNT_W'(1);
      if (inc_c && !dec_c)      total_d = total_q + TOT_W'(1);
      else if (dec_c && !inc_c) total_d = total_q - TOT_W'(1);
    end
    for (int r = 0; r < int'(NREG); r++) busy_d[r] = (cnt_d[r] != '0);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      busy_q  <= '0;
      total_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      total_q <= total_d;
    end
  end

  // A write-back must always retire a previously issued write.
  wb_underflow_a: assert property (@(posedge clk) disable iff (rst)
    (sb.wb_en && (sb.wb_dest != '0) && !sb.flush) |-> (cnt_q[sb.wb_dest] != '0));

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with hand-computed expectations.
module tb_regfile_scoreboard;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 2;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  regfile_scoreboard_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) sb_if ();

  regfile_scoreboard #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one decode/write-back pattern and let combinational outputs settle.
  task automatic apply(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                       input logic u2, input logic wr, input logic [4:0] dst,
                       input logic we, input logic [4:0] wd, input logic fl);
    sb_if.issue_valid    = v;
    sb_if.issue_src1     = s1;
    sb_if.issue_src2     = s2;
    sb_if.issue_use_src2 = u2;
    sb_if.issue_wr       = wr;
    sb_if.issue_dest     = dst;
    sb_if.wb_en          = we;
    sb_if.wb_dest        = wd;
    sb_if.flush          = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", sb_if.busy_mask, 32'h0);
    check("rst_total", 32'(sb_if.total_pending), 32'd0);
    rst = 1'b0;

    // 1: idle issue
    apply(1, 3, 4, 1, 0, 0, 0, 0, 0);
    check("t1_stall", 32'(sb_if.stall), 32'd0);
    check("t1_fire", 32'(sb_if.issue_fire), 32'd1);
    tick();
    check("t1_busy", sb_if.busy_mask, 32'h0);
    check("t1_total", 32'(sb_if.total_pending), 32'd0);

    // 2: RAW stall then bypass
    apply(1, 0, 0, 0, 1, 5, 0, 0, 0);
    check("t2_fire_wr", 32'(sb_if.issue_fire), 32'd1);
    tick();
    apply(1, 5, 0, 0, 0, 0, 0, 0, 0);
    check("t2_stall", 32'(sb_if.stall), 32'd1);
    check("t2_busy5", sb_if.busy_mask, 32'h20);
    repeat (3) tick();
    check("t2_stall_hold", 32'(sb_if.stall), 32'd1);
    apply(1, 5, 0, 0, 0, 0, 1, 5, 0);
    check("t2_bypass_stall", 32'(sb_if.stall), 32'd0);
    check("t2_bypass_fire", 32'(sb_if.issue_fire), 32'd1);
    tick();
    check("t2_busy_clr", sb_if.busy_mask, 32'h0);
    check("t2_total", 32'(sb_if.total_pending), 32'd0);

    // 3: saturation on r7
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 0, 0, 1, 7, 0, 0, 0);
      check("t3_fill_fire", 32'(sb_if.issue_fire), 32'd1);
      tick();
    end
    check("t3_total3", 32'(sb_if.total_pending), 32'd3);
    apply(1, 0, 0, 0, 1, 7, 0, 0, 0);
    check("t3_sat_stall", 32'(sb_if.stall), 32'd1);
    check("t3_sat_fire", 32'(sb_if.issue_fire), 32'd0);
    tick();
    check("t3_total_held", 32'(sb_if.total_pending), 32'd3);
    apply(1, 0, 0, 0, 1, 7, 1, 7, 0);
    check("t3_satwb_stall", 32'(sb_if.stall), 32'd0);
    check("t3_satwb_fire", 32'(sb_if.issue_fire), 32'd1);
    tick();
    check("t3_total_same", 32'(sb_if.total_pending), 32'd3);
    check("t3_busy7", sb_if.busy_mask, 32'h80);
    apply(0, 0, 0, 0, 1, 7, 0, 0, 0);
    check("t3_novalid_stall", 32'(sb_if.stall), 32'd0);
    apply(1, 7, 0, 0, 0, 0, 1, 7, 0);
    check("t3_nobypass_cnt3", 32'(sb_if.stall), 32'd1);
    tick();
    check("t3_total2", 32'(sb_if.total_pending), 32'd2);
    apply(0, 0, 0, 0, 0, 0, 1, 7, 0);
    tick();
    apply(1, 7, 0, 0, 0, 0, 1, 7, 0);
    check("t3_bypass_cnt1", 32'(sb_if.stall), 32'd0);
    tick();
    check("t3_drain_total", 32'(sb_if.total_pending), 32'd0);
    check("t3_drain_busy", sb_if.busy_mask, 32'h0);

    // 4: register 0 never tracked
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 0, 1, 1, 0, 1, 0, 0);
      check("t4_fire", 32'(sb_if.issue_fire), 32'd1);
      tick();
    end
    check("t4_busy", sb_if.busy_mask, 32'h0);
    check("t4_total", 32'(sb_if.total_pending), 32'd0);

    // 5: simultaneous inc/dec on different registers
    apply(1, 0, 0, 0, 1, 9, 0, 0, 0);
    tick();
    apply(1, 0, 0, 0, 1, 10, 1, 9, 0);
    check("t5_fire", 32'(sb_if.issue_fire), 32'd1);
    tick();
    check("t5_busy", sb_if.busy_mask, 32'h400);
    check("t5_total", 32'(sb_if.total_pending), 32'd1);
    apply(0, 0, 0, 0, 0, 0, 1, 10, 0);
    tick();
    check("t5_drain", 32'(sb_if.total_pending), 32'd0);

    // 6: flush, then asynchronous reset mid-cycle
    apply(1, 0, 0, 0, 1, 2, 0, 0, 0);
    tick();
    apply(1, 0, 0, 0, 1, 8, 0, 0, 0);
    tick();
    apply(1, 0, 0, 0, 1, 8, 0, 0, 0);
    tick();
    check("t6_busy_pre", sb_if.busy_mask, 32'h104);
    check("t6_total_pre", 32'(sb_if.total_pending), 32'd3);
    apply(1, 0, 0, 0, 1, 4, 0, 0, 1);
    tick();
    check("t6_flush_busy", sb_if.busy_mask, 32'h0);
    check("t6_flush_total", 32'(sb_if.total_pending), 32'd0);
    apply(1, 0, 0, 0, 1, 6, 0, 0, 0);
    tick();
    check("t6_busy6", sb_if.busy_mask, 32'h40);
    check("t6_total6", 32'(sb_if.total_pending), 32'd1);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    rst = 1'b1;
    #1;
    check("t6_async_busy", sb_if.busy_mask, 32'h0);
    check("t6_async_total", 32'(sb_if.total_pending), 32'd0);
    tick();
    rst = 1'b0;
    apply(1, 6, 0, 0, 0, 0, 0, 0, 0);
    check("t6_post_rst_stall", 32'(sb_if.stall), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
